// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared constants, FSM state encoding and column helpers for the
//             4x4 matrix keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_W = 5;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    // Display code meaning "no key"; the display renders it as blank.
    localparam logic [KEY_W-1:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Number of active-low columns in one row sample, saturating at 2
    // (two already means "ghost / multi-key").
    function automatic logic [1:0] low_count(input logic [COLS-1:0] col_n);
        logic [1:0] n;
        n = 2'd0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_n[c] && (n != 2'd2)) begin
                n = n + 2'd1;
            end
        end
        return n;
    endfunction

    // Index of the lowest-numbered active-low column (only meaningful when
    // exactly one column is low).
    function automatic logic [1:0] first_low(input logic [COLS-1:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_n[c]) begin
                idx = 2'(c);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_if
//  Purpose  : Keypad matrix pins plus the debounced key report.
//             master = scanner side, slave = keypad/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface keypad_scan_if;

    logic [3:0] row_out;
    logic [3:0] col_in;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_out,
        input  col_in,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        input  row_out,
        output col_in,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface
`default_nettype wire

// File: rtl/keypad_row_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_row_scan
//  Purpose  : Column synchronizer, row strobe rotation and per-scan key
//             collection. Emits a one-clock scan_done with the scan result
//             (single key code, or KEY_NONE for zero / multiple keys).
//  Revision : 1.0  initial release
// ============================================================================
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 12500
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_out,
    output logic              scan_done,
    output logic [KEY_W-1:0]  result
);

    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [COLS-1:0]  col_s1_q, col_s1_d;
    logic [COLS-1:0]  col_s2_q, col_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [ROWS-1:0]  row_out_q, row_out_d;
    logic [1:0]       hits_q, hits_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             scan_done_q, scan_done_d;
    logic [KEY_W-1:0] result_q, result_d;

    logic [1:0]       row_hits;
    logic [1:0]       row_col;
    logic [2:0]       hits_raw;
    logic [1:0]       hits_sum;
    logic [KEY_W-1:0] code_sum;

    // Next-state: advance the row window, fold the sampled row into the
    // running key tally, and publish the result after the last row.
    always_comb begin
        col_s1_d    = col_in;
        col_s2_d    = col_s1_q;
        div_d       = div_q + DIV_W'(1);
        row_d       = row_q;
        row_out_d   = row_out_q;
        hits_d      = hits_q;
        code_d      = code_q;
        scan_done_d = 1'b0;
        result_d    = result_q;

        row_hits = low_count(col_s2_q);
        row_col  = first_low(col_s2_q);
        hits_raw = {1'b0, hits_q} + {1'b0, row_hits};
        hits_sum = (hits_raw >= 3'd2) ? 2'd2 : hits_raw[1:0];
        // Keep the code from the first row that saw a key; any second hit
        // invalidates the scan anyway through hits_sum.
        code_sum = (hits_q == 2'd0) ? {1'b0, row_q, row_col} : code_q;

        if (div_q == DIV_LAST) begin
            div_d     = '0;
            row_d     = row_q + 2'd1;
            row_out_d = {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
            if (row_q == 2'(ROWS - 1)) begin
                scan_done_d = 1'b1;
                result_d    = (hits_sum == 2'd1) ? code_sum : KEY_NONE;
                hits_d      = 2'd0;
                code_d      = '0;
            end else begin
                hits_d = hits_sum;
                code_d = code_sum;
            end
        end
    end

    // State registers; columns idle high through reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            col_s1_q    <= '1;
            col_s2_q    <= '1;
            div_q       <= '0;
            row_q       <= 2'd0;
            row_out_q   <= 4'b1110;
            hits_q      <= 2'd0;
            code_q      <= '0;
            scan_done_q <= 1'b0;
            result_q    <= KEY_NONE;
        end else begin
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
            div_q       <= div_d;
            row_q       <= row_d;
            row_out_q   <= row_out_d;
            hits_q      <= hits_d;
            code_q      <= code_d;
            scan_done_q <= scan_done_d;
            result_q    <= result_d;
        end
    end

    assign row_out   = row_out_q;
    assign scan_done = scan_done_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : 4x4 matrix keypad scanner with press/release debouncing.
//             Reports one hex key in the display's 5-bit code format.
//  Options  : define KEYPAD_REPEAT_EN to enable key_valid auto-repeat.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic          clk,
    input  logic          rst_,
    keypad_scan_if.master kp
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic             scan_done;
    logic [KEY_W-1:0] result;
    logic [ROWS-1:0]  row_out;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_target;
    logic             rep_first_q, rep_first_d;
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    keypad_row_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scan (
        .clk       (clk),
        .rst_      (rst_),
        .col_in    (kp.col_in),
        .row_out   (row_out),
        .scan_done (scan_done),
        .result    (result)
    );

    // Debounce FSM, stepped once per completed scan.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cnt_inc     = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_inc     = rep_cnt_q + REP_W'(1);
        rep_target  = rep_first_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
`endif

        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (result != KEY_NONE) begin
                        state_d = DEBOUNCE;
                        cand_d  = result;
                        cnt_d   = CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (result == KEY_NONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (result == cand_q) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_d     = PRESSED;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            key_held_d  = 1'b1;
                            key_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cand_d = result;
                        cnt_d  = CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (result == cand_q) begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_inc == rep_target) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
`endif
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (result != cand_q) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_code_d = KEY_NONE;
                            key_held_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            cand_q      <= KEY_NONE;
            cnt_q       <= '0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign kp.row_out   = row_out;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan
//  Purpose  : Self-checking bench for keypad_scan. A scan-level model of the
//             press/release rules predicts the outputs every clock; directed
//             scenarios add literal expectations on codes and pulse counts.
//  Options  : honours KEYPAD_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int RD       = 4;
    localparam int RR       = 2;
    localparam int SCAN_LEN = 4 * SCAN_DIV;

    logic        clk  = 1'b0;
    logic        rst_ = 1'b0;
    logic [15:0] mask = 16'h0;   // set of keys physically closed
    logic [3:0]  col_drv;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulses       = 0;
    int edges        = 0;

    always #5 clk = ~clk;

    keypad_scan_if kp ();

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .kp   (kp)
    );

    // Passive matrix: a closed key pulls its column low while its row is driven low.
    always_comb begin
        col_drv = 4'hf;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[r*4+c] && !kp.row_out[r]) begin
                    col_drv[c] = 1'b0;
                end
            end
        end
    end
    assign kp.col_in = col_drv;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scan-level reference model ----------------
    int m_acc    = -1;   // accepted key, -1 when none
    int m_cand   = -1;
    int m_streak = 0;
    int m_miss   = 0;
    int m_rep    = 0;
    int m_pend   = 16;
    bit m_valid  = 1'b0;

    function automatic int scan_result(input logic [15:0] m);
        int idx;
        idx = 16;
        if ($countones(m) == 1) begin
            for (int k = 0; k < 16; k++) begin
                if (m[k]) idx = k;
            end
        end
        return idx;
    endfunction

    task automatic model_apply(input int res);
        if (m_acc < 0) begin
            if (res == 16) begin
                m_streak = 0;
            end else if (m_streak > 0 && res == m_cand) begin
                m_streak++;
            end else begin
                m_cand   = res;
                m_streak = 1;
            end
            if (m_streak >= DB) begin
                m_acc    = m_cand;
                m_streak = 0;
                m_miss   = 0;
                m_rep    = 0;
                m_valid  = 1'b1;
            end
        end else if (res == m_acc) begin
            if (m_miss > 0) begin
                m_miss = 0;
                m_rep  = 0;
            end else begin
                m_rep++;
`ifdef KEYPAD_REPEAT_EN
                if (m_rep == RD || (m_rep > RD && ((m_rep - RD) % RR) == 0)) begin
                    m_valid = 1'b1;
                end
`endif
            end
        end else begin
            m_miss++;
            if (m_miss >= DB) begin
                m_acc  = -1;
                m_miss = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            edges <= 0;
        end else begin
            edges <= edges + 1;
        end
    end

    // Scan s occupies edges [16s, 16s+15]; its outcome is visible after edge 16s+16.
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_acc = -1; m_cand = -1; m_streak = 0; m_miss = 0; m_rep = 0;
            m_pend = 16; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (edges % SCAN_LEN == 0 && edges > 0) model_apply(m_pend);
            if (edges % SCAN_LEN == SCAN_LEN - 1) m_pend = scan_result(mask);
        end
    end

    always @(posedge clk) begin
        if (rst_ && kp.key_valid) pulses++;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [3:0] one;
        logic [3:0] exp_row;
        one     = 4'b0001;
        exp_row = ~(one << ((edges / SCAN_DIV) % 4));
        chk("row_out",   int'(kp.row_out),   int'(exp_row));
        chk("key_code",  int'(kp.key_code),  (m_acc < 0) ? 16 : m_acc);
        chk("key_held",  int'(kp.key_held),  (m_acc >= 0) ? 1 : 0);
        chk("key_valid", int'(kp.key_valid), int'(m_valid));
    end

    // Hold a key set for n whole scans, starting on a scan boundary.
    task automatic scans(input logic [15:0] m, input int n);
        while (edges % SCAN_LEN != 0) @(negedge clk);
        mask = m;
        repeat (SCAN_LEN * n) @(negedge clk);
    endtask

    int p0;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_row_out",   int'(kp.row_out),   4'b1110);
        chk("rst_key_code",  int'(kp.key_code),  5'h10);
        chk("rst_key_valid", int'(kp.key_valid), 0);
        chk("rst_key_held",  int'(kp.key_held),  0);
        #2 rst_ = 1'b1;

        // Single key at row 2 / col 1 -> code 9
        scans(16'h0200, 4);
        @(negedge clk);
        chk("single_code", int'(kp.key_code), 5'h9);
        chk("single_held", int'(kp.key_held), 1);
        chk("single_pulses", pulses, 1);
        scans(16'h0000, 4);
        chk("release_code", int'(kp.key_code), 5'h10);
        chk("release_held", int'(kp.key_held), 0);
        chk("release_pulses", pulses, 1);

        // Bounce on key 3
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            scans(16'h0008, 1);
            scans(16'h0000, 1);
        end
        scans(16'h0000, 1);
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_code", int'(kp.key_code), 5'h10);

        // Ghost: keys 0 and 5 together
        p0 = pulses;
        scans(16'h0021, 5);
        scans(16'h0000, 1);
        chk("ghost_pulses", pulses - p0, 0);
        chk("ghost_code", int'(kp.key_code), 5'h10);

        // Two keys in one row (keys 4 and 6)
        p0 = pulses;
        scans(16'h0050, 4);
        chk("samerow_pulses", pulses - p0, 0);

        // Rollover 5 -> 7
        p0 = pulses;
        scans(16'h0020, 4);
        chk("roll_first_code", int'(kp.key_code), 5'h5);
        scans(16'h0080, 3);
        @(negedge clk);
        chk("roll_gap_code", int'(kp.key_code), 5'h10);
        scans(16'h0080, 4);
        chk("roll_second_code", int'(kp.key_code), 5'h7);
        chk("roll_pulses", pulses - p0, 2);
        scans(16'h0000, 4);

        // Reset after two matching scans of key 0xc
        p0 = pulses;
        scans(16'h1000, 2);
        repeat (2) @(negedge clk);
        #2 rst_ = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_row_out",  int'(kp.row_out),  4'b1110);
        chk("mid_rst_key_code", int'(kp.key_code), 5'h10);
        chk("mid_rst_key_held", int'(kp.key_held), 0);
        mask = 16'h0000;
        @(negedge clk);
        #2 rst_ = 1'b1;
        scans(16'h0000, 2);
        chk("mid_rst_pulses", pulses - p0, 0);

        // Long hold of key 6: auto-repeat when enabled
        p0 = pulses;
        scans(16'h0040, 12);
        chk("hold_code", int'(kp.key_code), 5'h6);
`ifdef KEYPAD_REPEAT_EN
        chk("hold_pulses", pulses - p0, 4);
`else
        chk("hold_pulses", pulses - p0, 1);
`endif
        scans(16'h0000, 4);
        chk("final_code", int'(kp.key_code), 5'h10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
